// File: rtl/servo_pkg.sv
// Shared types for the servo command sequencer: ratio width, FSM states
// and the queued command payload.
package servo_pkg;

  localparam int unsigned PWM_RATIO_W = 8;
  localparam int unsigned CMD_DWELL_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DWELL = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [PWM_RATIO_W-1:0] ratio;
    logic [CMD_DWELL_W-1:0] dwell;
  } cmd_t;

endpackage

// File: rtl/servo_cmd_seq_if.sv
// Command push channel (valid/ready with ratio and dwell payload) into the
// servo command sequencer.
interface servo_cmd_seq_if #(
  parameter int unsigned DWELL_W = servo_pkg::CMD_DWELL_W
) ();

  logic                               cmd_valid;
  logic                               cmd_ready;
  logic [servo_pkg::PWM_RATIO_W-1:0]  cmd_ratio;
  logic [DWELL_W-1:0]                 cmd_dwell;

  modport master (
    output cmd_valid,
    output cmd_ratio,
    output cmd_dwell,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_ratio,
    input  cmd_dwell,
    output cmd_ready
  );

endinterface

// File: rtl/servo_cmd_fifo.sv
// Synchronous command FIFO with push/pop/flush; head is read combinationally,
// level is registered. Flush wins over push and pop in the same cycle.
module servo_cmd_fifo
  import servo_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  cmd_t                     wdata,
  output cmd_t                     head_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full_c  = (level == LW'(DEPTH));
  assign empty_c = (level == '0);
  assign head_c  = mem[rd_ptr];

  assign do_push = push && !full_c && !flush;
  assign do_pop  = pop && !empty_c && !flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/servo_cmd_seq.sv
// Command sequencer feeding servo_ctrl: pops (ratio, dwell) commands and holds
// each ratio for its dwell. Optional ratio clamp enabled by `SERVO_CLAMP_EN.
module servo_cmd_seq
  import servo_pkg::*;
#(
  parameter int unsigned            FIFO_DEPTH = 4,
  parameter int unsigned            DWELL_W    = CMD_DWELL_W,
  parameter logic [PWM_RATIO_W-1:0] PARK_RATIO = 8'd20
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           seq_enable,
  input  logic                           abort,
  servo_cmd_seq_if.slave                 cmd,
`ifdef SERVO_CLAMP_EN
  input  logic [PWM_RATIO_W-1:0]         min_pwm_ratio,
  input  logic [PWM_RATIO_W-1:0]         max_pwm_ratio,
`endif
  output logic                           pwm_enable,
  output logic [PWM_RATIO_W-1:0]         start_pwm_ratio,
  output logic [PWM_RATIO_W-1:0]         target_pwm_ratio,
  output logic                           busy,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           cmd_done
);

  seq_state_t               state;
  logic [DWELL_W-1:0]       dwell_cnt;
  logic [DWELL_W-1:0]       head_dwell_c;
  logic [PWM_RATIO_W-1:0]   ratio_c;
  cmd_t                     wdata_c;
  cmd_t                     head_c;
  logic                     full_c;
  logic                     empty_c;
  logic                     push_c;
  logic                     pop_c;

  assign start_pwm_ratio = PARK_RATIO;
  assign cmd.cmd_ready   = !full_c && !abort;
  assign push_c          = cmd.cmd_valid && cmd.cmd_ready;
  assign pop_c           = (state == LOAD);
  assign wdata_c         = '{ratio: cmd.cmd_ratio, dwell: CMD_DWELL_W'(cmd.cmd_dwell)};
  assign head_dwell_c    = DWELL_W'(head_c.dwell);

  servo_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push_c),
    .pop     (pop_c),
    .flush   (abort),
    .wdata   (wdata_c),
    .head_c  (head_c),
    .full_c  (full_c),
    .empty_c (empty_c),
    .level   (fifo_level)
  );

  // Ratio presented on load; the floor check is evaluated first so it wins
  // when the limits are inverted.
  always_comb begin
    ratio_c = head_c.ratio;
`ifdef SERVO_CLAMP_EN
    if (head_c.ratio < min_pwm_ratio) begin
      ratio_c = min_pwm_ratio;
    end else if (head_c.ratio > max_pwm_ratio) begin
      ratio_c = max_pwm_ratio;
    end
`endif
  end

  // cmd_done is registered one edge early so it lines up with the cycle in
  // which the dwell counter reads zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      dwell_cnt        <= '0;
      target_pwm_ratio <= PARK_RATIO;
      pwm_enable       <= 1'b0;
      busy             <= 1'b0;
      cmd_done         <= 1'b0;
    end else begin
      pwm_enable <= seq_enable;
      cmd_done   <= 1'b0;
      if (abort) begin
        state            <= IDLE;
        busy             <= 1'b0;
        dwell_cnt        <= '0;
        target_pwm_ratio <= PARK_RATIO;
      end else begin
        unique case (state)
          IDLE: begin
            if (seq_enable && !empty_c) begin
              state <= LOAD;
              busy  <= 1'b1;
            end
          end
          LOAD: begin
            target_pwm_ratio <= ratio_c;
            dwell_cnt        <= head_dwell_c;
            cmd_done         <= (head_dwell_c == '0);
            state            <= DWELL;
            busy             <= 1'b1;
          end
          DWELL: begin
            if (dwell_cnt != '0) begin
              dwell_cnt <= dwell_cnt - DWELL_W'(1);
              cmd_done  <= (dwell_cnt == DWELL_W'(1));
            end else if (seq_enable && !empty_c) begin
              state <= LOAD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_servo_cmd_seq.sv
// Directed self-checking bench for servo_cmd_seq; outputs sampled on the
// falling clock edge, inputs driven there too.
module tb_servo_cmd_seq;
  import servo_pkg::*;

  logic       clock;
  logic       reset_n;
  logic       seq_enable;
  logic       abort;
  logic       pwm_enable;
  logic [7:0] start_pwm_ratio;
  logic [7:0] target_pwm_ratio;
  logic       busy;
  logic [2:0] fifo_level;
  logic       cmd_done;
`ifdef SERVO_CLAMP_EN
  logic [7:0] min_pwm_ratio;
  logic [7:0] max_pwm_ratio;
`endif

  int n_cmp;
  int n_err;

  logic [7:0] exp_r   [4] = '{8'd10, 8'd60, 8'd30, 8'd80};
  int         exp_gap [4] = '{2, 7, 7, 2};

  servo_cmd_seq_if #(.DWELL_W(16)) cmd_if ();

  servo_cmd_seq dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .seq_enable       (seq_enable),
    .abort            (abort),
    .cmd              (cmd_if),
`ifdef SERVO_CLAMP_EN
    .min_pwm_ratio    (min_pwm_ratio),
    .max_pwm_ratio    (max_pwm_ratio),
`endif
    .pwm_enable       (pwm_enable),
    .start_pwm_ratio  (start_pwm_ratio),
    .target_pwm_ratio (target_pwm_ratio),
    .busy             (busy),
    .fifo_level       (fifo_level),
    .cmd_done         (cmd_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input logic [7:0] r, input logic [15:0] d);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_ratio = r;
    cmd_if.cmd_dwell = d;
    tick(1);
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Single zero-dwell command from idle with an empty FIFO.
  task automatic run_one(input logic [7:0] r, input logic [7:0] exp, input string tag);
    push(r, 16'd0);
    tick(2);
    check(tag, 32'(target_pwm_ratio), 32'(exp));
    tick(1);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int t;
    int last_t;
    int nchg;
    int ndone;
    logic [7:0] prev;

    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b1;
    seq_enable = 1'b0;
    abort = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_ratio = '0;
    cmd_if.cmd_dwell = '0;
`ifdef SERVO_CLAMP_EN
    min_pwm_ratio = 8'd0;
    max_pwm_ratio = 8'd255;
`endif
    #2 reset_n = 1'b0;
    #1;
    check("rst_target", 32'(target_pwm_ratio), 32'd20);
    check("rst_start", 32'(start_pwm_ratio), 32'd20);
    check("rst_pwm_en", 32'(pwm_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(cmd_done), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    tick(2);
    reset_n = 1'b1;
    tick(1);

    // Single long command: latency to target and to cmd_done.
    seq_enable = 1'b1;
    tick(1);
    check("pwm_en_follow", 32'(pwm_enable), 32'd1);
    push(8'd50, 16'd100);
    check("p1_level", 32'(fifo_level), 32'd1);
    check("p1_busy_idle", 32'(busy), 32'd0);
    tick(1);
    check("p1_busy_load", 32'(busy), 32'd1);
    tick(1);
    check("p1_target", 32'(target_pwm_ratio), 32'd50);
    check("p1_level_pop", 32'(fifo_level), 32'd0);
    check("p1_done_early", 32'(cmd_done), 32'd0);
    t = 0;
    while (cmd_done !== 1'b1 && t < 300) begin
      tick(1);
      t++;
    end
    check("p1_done_lat", 32'(t), 32'd100);
    check("p1_busy_last", 32'(busy), 32'd1);
    tick(1);
    check("p1_done_pulse", 32'(cmd_done), 32'd0);
    check("p1_back_idle", 32'(busy), 32'd0);

    // Fill the FIFO while disabled, then drain in order.
    seq_enable = 1'b0;
    tick(1);
    push(8'd10, 16'd5);
    push(8'd60, 16'd5);
    push(8'd30, 16'd0);
    push(8'd80, 16'd3);
    check("full_level", 32'(fifo_level), 32'd4);
    check("full_ready", 32'(cmd_if.cmd_ready), 32'd0);
    push(8'd99, 16'd1);
    check("full_no_push", 32'(fifo_level), 32'd4);
    seq_enable = 1'b1;
    prev = target_pwm_ratio;
    t = 0;
    last_t = 0;
    nchg = 0;
    ndone = 0;
    while ((nchg < 4 || busy) && t < 200) begin
      tick(1);
      t++;
      if (cmd_done) ndone++;
      if (target_pwm_ratio != prev) begin
        if (nchg < 4) begin
          check("seq_ratio", 32'(target_pwm_ratio), 32'(exp_r[nchg]));
          check("seq_gap", 32'(t - last_t), 32'(exp_gap[nchg]));
        end
        if (nchg == 2) check("dwell0_done", 32'(cmd_done), 32'd1);
        last_t = t;
        prev = target_pwm_ratio;
        nchg++;
      end
    end
    check("seq_changes", 32'(nchg), 32'd4);
    check("seq_done_cnt", 32'(ndone), 32'd4);
    check("seq_level", 32'(fifo_level), 32'd0);

    // Abort during a long dwell with two queued; concurrent push is dropped.
    push(8'd75, 16'd1000);
    push(8'd11, 16'd5);
    push(8'd22, 16'd5);
    check("ab_target", 32'(target_pwm_ratio), 32'd75);
    check("ab_level_pp", 32'(fifo_level), 32'd2);
    tick(10);
    abort = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_ratio = 8'd99;
    cmd_if.cmd_dwell = 16'd1;
    #1;
    check("ab_ready", 32'(cmd_if.cmd_ready), 32'd0);
    @(negedge clock);
    abort = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    check("ab_park", 32'(target_pwm_ratio), 32'd20);
    check("ab_level", 32'(fifo_level), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    ndone = 0;
    nchg = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (cmd_done) ndone++;
      if (target_pwm_ratio != 8'd20 || busy) nchg++;
    end
    check("ab_no_done", 32'(ndone), 32'd0);
    check("ab_stays_parked", 32'(nchg), 32'd0);

    // Disable mid-dwell: dwell completes, queue retained, resumes on enable.
    push(8'd33, 16'd10);
    push(8'd44, 16'd2);
    tick(1);
    check("en_target", 32'(target_pwm_ratio), 32'd33);
    check("en_level", 32'(fifo_level), 32'd1);
    tick(3);
    seq_enable = 1'b0;
    #1;
    check("en_pwm_hold", 32'(pwm_enable), 32'd1);
    tick(1);
    check("en_pwm_drop", 32'(pwm_enable), 32'd0);
    t = 0;
    while (cmd_done !== 1'b1 && t < 50) begin
      tick(1);
      t++;
    end
    check("en_done_seen", 32'(cmd_done), 32'd1);
    check("en_target_held", 32'(target_pwm_ratio), 32'd33);
    tick(1);
    check("en_idle", 32'(busy), 32'd0);
    check("en_retained", 32'(fifo_level), 32'd1);
    tick(5);
    check("en_still_idle", 32'(busy), 32'd0);
    check("en_still_retained", 32'(fifo_level), 32'd1);
    seq_enable = 1'b1;
    tick(2);
    check("en_resume", 32'(target_pwm_ratio), 32'd44);
    check("en_resume_level", 32'(fifo_level), 32'd0);
    t = 0;
    while (busy && t < 20) begin
      tick(1);
      t++;
    end
    check("en_resume_idle", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a dwell.
    push(8'd66, 16'd50);
    push(8'd77, 16'd50);
    tick(1);
    check("rd_target", 32'(target_pwm_ratio), 32'd66);
    check("rd_level", 32'(fifo_level), 32'd1);
    tick(5);
    reset_n = 1'b0;
    #1;
    check("rd_target_rst", 32'(target_pwm_ratio), 32'd20);
    check("rd_busy_rst", 32'(busy), 32'd0);
    check("rd_pwm_rst", 32'(pwm_enable), 32'd0);
    check("rd_done_rst", 32'(cmd_done), 32'd0);
    check("rd_level_rst", 32'(fifo_level), 32'd0);
    tick(1);
    reset_n = 1'b1;
    tick(1);

`ifdef SERVO_CLAMP_EN
    min_pwm_ratio = 8'd15;
    max_pwm_ratio = 8'd60;
    run_one(8'd5, 8'd15, "clamp_floor");
    run_one(8'd90, 8'd60, "clamp_ceil");
    run_one(8'd40, 8'd40, "clamp_pass");
    min_pwm_ratio = 8'd50;
    max_pwm_ratio = 8'd30;
    run_one(8'd40, 8'd50, "clamp_inverted");
`else
    run_one(8'd5, 8'd5, "raw_low");
    run_one(8'd90, 8'd90, "raw_high");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
